mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline, fed directly by the EX/MEM register outputs.
//  Performs data-memory load/store with configurable multi-cycle latency (stall handshake).
//  Resolves branch/jump select for the PC mux.
//  Registers results into MEM/WB outputs for the write-back stage.
// PARAMETERS
//  DEPTH    256  data memory size in 32-bit words (power of 2)
//  MEM_LAT  2    cycles per load/store access, >=1; MEM_LAT=1 means no stall
// PORTS
//  clk                input   1   rising-edge clock
//  rst                input   1   asynchronous, active-high reset
//  pcAdded            input   32  branch/jump target from EX/MEM
//  zeroFlag           input   1   ALU zero from EX/MEM
//  aluResult          input   32  byte address / ALU result from EX/MEM
//  writeData          input   32  store data from EX/MEM
//  muxRegFileData     input   5   destination register from EX/MEM
//  branch, jump       input   1   control from EX/MEM
//  memWrite, memRead  input   1   control from EX/MEM
//  regWrite, memToReg input   1   control from EX/MEM (WB group)
//  pcSrc              output  1   comb: (branch & zeroFlag) | jump
//  pcTarget           output  32  comb: = pcAdded
//  stall              output  1   comb: hold PC, IF/ID, ID/EX and EX/MEM this cycle
//  outReadData        output  32  MEM/WB: loaded word
//  outAluResult       output  32  MEM/WB: aluResult passthrough
//  outMuxRegFileData  output  5   MEM/WB: destination register
//  outRegWrite        output  1   MEM/WB: register write enable
//  outMemToReg        output  1   MEM/WB: WB mux select
//  addrErr            output  1   MEM/WB: last access was out of range
// BEHAVIOUR
//  Reset: all MEM/WB outputs and addrErr = 0; FSM = IDLE; cnt = 0.
//   Reset does not touch memory contents; memory is zero at time 0.
//   Reset mid-access aborts it: the pending store is not committed.
//  Address: word index = aluResult[log2(DEPTH)+1:2]; bits [1:0] are ignored.
//   Out of range (aluResult >= 4*DEPTH): load returns 0, store is dropped, addrErr = 1.
//  Access request: req = memRead | memWrite.
//   If memRead & memWrite are both set, it is a store; outReadData = 0.
//  FSM states: IDLE, WAIT.
//  IDLE, no req: no stall. At posedge, MEM/WB <= inputs; outReadData = 0; addrErr = 0.
//  IDLE, req, MEM_LAT = 1: no stall. Commit at this posedge: the store writes memory;
//   the load captures mem[idx] into outReadData.
//  IDLE, req, MEM_LAT > 1: stall = 1. At posedge go to WAIT with cnt = 1.
//   MEM/WB gets a bubble: outRegWrite = 0, outMemToReg = 0, other fields hold.
//  WAIT, cnt < MEM_LAT-1: stall = 1; cnt++; bubble in MEM/WB.
//  WAIT, cnt == MEM_LAT-1: stall = 0. Commit at this posedge, exactly once.
//   Then MEM/WB <= inputs plus read data; go to IDLE; cnt = 0.
//  Upstream holds all inputs stable while stall = 1.
//   The store commits once per instruction, never during stall cycles.
//  Load latency: data is visible on outReadData MEM_LAT cycles after the request is first seen.
//  Same-cycle store then load to the same address: the load sees the new data (sequential order).
//  pcSrc/pcTarget follow the inputs combinationally and are not gated by stall or rst.
// TESTING
//  T1 reset: assert rst mid-WAIT of a store (sw 0xDEADBEEF to 0x10), then read 0x10
//   -> FSM in IDLE, outputs 0, load returns 0.
//  T2 MEM_LAT=2: sw 0xCAFEF00D to addr 0x20, then lw 0x20 to r5
//   -> stall high 1 cycle per access; outReadData = 0xCAFEF00D; outMuxRegFileData = 5; outRegWrite = 1.
//  T3 ALU op with no req (aluResult = 7, r3, regWrite = 1)
//   -> next cycle outAluResult = 7, outRegWrite = 1, stall never asserted.
//  T4 out of range (DEPTH=256): sw to 0x400, then lw 0x400
//   -> addrErr = 1, outReadData = 0, mem[0] unchanged.
//  T5 branch = 1, zeroFlag = 1, pcAdded = 0x40 -> pcSrc = 1, pcTarget = 0x40;
//   zeroFlag = 0 -> pcSrc = 0; jump = 1 -> pcSrc = 1.
//  T6 MEM_LAT=3: stall held 2 cycles during a store; memory is written exactly once
//   (checked with a write counter); bubbles carry outRegWrite = 0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM stage -> MEM/WB signal bundle, including the PC-select and stall feedback.
// The driver of the EX/MEM side uses 'master'; the MEM stage itself uses 'slave'.
interface mem_access_stage_if;
    logic [31:0] pcAdded;
    logic        zeroFlag;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [4:0]  muxRegFileData;
    logic        branch;
    logic        jump;
    logic        memWrite;
    logic        memRead;
    logic        regWrite;
    logic        memToReg;

    logic        pcSrc;
    logic [31:0] pcTarget;
    logic        stall;
    logic [31:0] outReadData;
    logic [31:0] outAluResult;
    logic [4:0]  outMuxRegFileData;
    logic        outRegWrite;
    logic        outMemToReg;
    logic        addrErr;

    modport master (
        output pcAdded, zeroFlag, aluResult, writeData, muxRegFileData,
               branch, jump, memWrite, memRead, regWrite, memToReg,
        input  pcSrc, pcTarget, stall, outReadData, outAluResult,
               outMuxRegFileData, outRegWrite, outMemToReg, addrErr
    );

    modport slave (
        input  pcAdded, zeroFlag, aluResult, writeData, muxRegFileData,
               branch, jump, memWrite, memRead, regWrite, memToReg,
        output pcSrc, pcTarget, stall, outReadData, outAluResult,
               outMuxRegFileData, outRegWrite, outMemToReg, addrErr
    );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: word-addressed data memory with MEM_LAT-cycle access and upstream stall,
// branch/jump PC select, and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr[31:AW+2] == {(30-AW){1'b0}});
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
        return addr[AW+1:2];
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nxt_s;
    logic           stall_s;
    logic           load_wb_s;
    logic           req_s;
    logic           is_store_s;
    logic           is_load_s;
    logic           in_range_s;
    logic [AW-1:0]  idx_s;
    logic           mem_we_s;
    logic [31:0]    rd_word_s;
    logic           addr_unused_s;
    logic [31:0]    mem_r [0:DEPTH-1];

    logic [31:0]    out_read_data_r;
    logic [31:0]    out_alu_result_r;
    logic [4:0]     out_dst_r;
    logic           out_reg_write_r;
    logic           out_mem_to_reg_r;
    logic           addr_err_r;

    assign req_s         = bus.memRead | bus.memWrite;
    assign is_store_s    = bus.memWrite;
    assign is_load_s     = bus.memRead & ~bus.memWrite;
    assign in_range_s    = addr_in_range(bus.aluResult);
    assign idx_s         = word_index(bus.aluResult);
    assign addr_unused_s = ^bus.aluResult[1:0];

    // Access sequencing: decides stall, when MEM/WB loads, and the wait counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        load_wb_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!req_s) begin
                    load_wb_s = 1'b1;
                end else if (MEM_LAT == 1) begin
                    load_wb_s = 1'b1;
                end else begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_LAST) begin
                    load_wb_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Stores land only on the commit edge; reset held across an edge suppresses them.
    assign mem_we_s  = load_wb_s & req_s & is_store_s & in_range_s & ~rst;
    assign rd_word_s = (is_load_s & in_range_s) ? mem_r[idx_s] : 32'h0000_0000;

    // FSM state and wait-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Data memory array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= bus.writeData;
        end
    end

    // MEM/WB register: loads on a non-stalled edge, becomes a bubble while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_read_data_r  <= 32'h0000_0000;
            out_alu_result_r <= 32'h0000_0000;
            out_dst_r        <= 5'd0;
            out_reg_write_r  <= 1'b0;
            out_mem_to_reg_r <= 1'b0;
            addr_err_r       <= 1'b0;
        end else if (load_wb_s) begin
            out_read_data_r  <= rd_word_s;
            out_alu_result_r <= bus.aluResult;
            out_dst_r        <= bus.muxRegFileData;
            out_reg_write_r  <= bus.regWrite;
            out_mem_to_reg_r <= bus.memToReg;
            addr_err_r       <= req_s & ~in_range_s;
        end else if (stall_s) begin
            out_reg_write_r  <= 1'b0;
            out_mem_to_reg_r <= 1'b0;
        end
    end

    assign bus.pcSrc             = (bus.branch & bus.zeroFlag) | bus.jump;
    assign bus.pcTarget          = bus.pcAdded;
    assign bus.stall             = stall_s;
    assign bus.outReadData       = out_read_data_r;
    assign bus.outAluResult      = out_alu_result_r;
    assign bus.outMuxRegFileData = out_dst_r;
    assign bus.outRegWrite       = out_reg_write_r;
    assign bus.outMemToReg       = out_mem_to_reg_r;
    assign bus.addrErr           = addr_err_r;
endmodule
